// File: rtl/bp_lce_cmd_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// bp_lce_cmd_deserializer_pkg
//
// Shared definitions for the LCE command deserializer:
//   - bp_lce_cmd_deser_state_e : reassembly FSM states
//   - bp_msg_size_to_flits()   : number of data flits carried by a message
//                                of a given encoded size (payload = 2^size B)
// ---------------------------------------------------------------------------
package bp_lce_cmd_deserializer_pkg;

    typedef enum logic [1:0] {
        e_header = 2'd0,
        e_data   = 2'd1,
        e_out    = 2'd2
    } bp_lce_cmd_deser_state_e;

    // Payload bits are clamped to the block width, and a payload smaller
    // than a flit still travels in exactly one flit.
    function automatic int bp_msg_size_to_flits(input logic [2:0] size,
                                                input int flit_width,
                                                input int block_width);
        int bits;
        int flits;
        bits = 8 << size;
        if (bits > block_width) begin
            bits = block_width;
        end
        flits = bits / flit_width;
        if (flits < 1) begin
            flits = 1;
        end
        return flits;
    endfunction

endpackage

// File: rtl/bp_me_flit_collector.sv
// ---------------------------------------------------------------------------
// bp_me_flit_collector
//
// Slice-indexed (shift-free) assembly register. Each write stores flit_i into
// slice [cnt*flit_width_p +: flit_width_p] and advances the write counter.
// The write that lands on last_cnt_i wraps the counter back to 0 so it never
// counts past its terminal value. Bits of the final slice beyond width_p are
// dropped.
//
// Ports:
//   clk_i        in   clock
//   reset_i      in   synchronous active-high reset (register and count to 0)
//   clear_i      in   zero the register and the count
//   write_i      in   store flit_i in the current slice
//   flit_i       in   incoming flit
//   last_cnt_i   in   index of the final slice for the current message
//   last_o       out  current slice is the final one
//   data_o       out  registered assembled value
//   data_next_o  out  value the register takes this cycle, including flit_i
// ---------------------------------------------------------------------------
module bp_me_flit_collector #(
    parameter int width_p      = 96,
    parameter int flit_width_p = 64,
    parameter int cnt_width_p  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   write_i,
    input  logic [flit_width_p-1:0] flit_i,
    input  logic [cnt_width_p-1:0] last_cnt_i,
    output logic                   last_o,
    output logic [width_p-1:0]     data_o,
    output logic [width_p-1:0]     data_next_o
);

    localparam int num_flits_lp    = (width_p + flit_width_p - 1) / flit_width_p;
    localparam int padded_width_lp = num_flits_lp * flit_width_p;

    logic [width_p-1:0]         data_r;
    logic [padded_width_lp-1:0] data_n;
    logic [cnt_width_p-1:0]     cnt;

    assign last_o = (cnt == last_cnt_i);

    bsg_counter_clear_up #(
        .max_val_p  ((1 << cnt_width_p) - 1),
        .init_val_p (0)
    ) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i | (write_i & last_o)),
        .up_i    (write_i & ~last_o),
        .count_o (cnt)
    );

    // Working copy is padded to whole flits so every slice write is in range.
    always_comb begin
        data_n = '0;
        data_n[width_p-1:0] = data_r;
        if (write_i) begin
            for (int i = 0; i < num_flits_lp; i++) begin
                if (cnt == cnt_width_p'(i)) begin
                    data_n[i*flit_width_p +: flit_width_p] = flit_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= '0;
        end else if (clear_i) begin
            data_r <= '0;
        end else begin
            data_r <= data_n[width_p-1:0];
        end
    end

    assign data_o      = data_r;
    assign data_next_o = data_n[width_p-1:0];

    // Padding bits above width_p are intentionally discarded.
    if (padded_width_lp > width_p) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^data_n[padded_width_lp-1:width_p];
    end

endmodule

// File: rtl/bsg_counter_clear_up.sv
// ---------------------------------------------------------------------------
// bsg_counter_clear_up
//
// Up counter with synchronous clear. When clear_i and up_i are both high the
// count restarts at the value of up_i (clear first, then count).
//
// Ports:
//   clk_i    in   clock
//   reset_i  in   synchronous active-high reset (count <= init_val_p)
//   clear_i  in   restart the count
//   up_i     in   increment
//   count_o  out  current count
// ---------------------------------------------------------------------------
module bsg_counter_clear_up #(
    parameter int max_val_p  = 15,
    parameter int init_val_p = 0,
    localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= ptr_width_lp'(init_val_p);
        end else if (clear_i) begin
            count_o <= ptr_width_lp'(up_i);
        end else if (up_i) begin
            count_o <= count_o + ptr_width_lp'(1);
        end
    end

endmodule

// File: rtl/bp_lce_cmd_deserializer.sv
// ---------------------------------------------------------------------------
// bp_lce_cmd_deserializer
//
// Reassembles LCE command messages arriving as NoC flits (header flits, then
// optional data flits) into one {data, header} message and holds it for the
// LCE until it is consumed. One message is buffered; no new flit is accepted
// while a completed message is waiting.
//
// Ports:
//   clk_i           in   clock
//   reset_i         in   synchronous active-high reset
//   flit_i          in   incoming NoC flit
//   flit_v_i        in   flit valid
//   flit_ready_o    out  a flit can be accepted this cycle
//   lce_cmd_o       out  reassembled message, header in the LSBs
//   lce_cmd_v_o     out  reassembled message valid
//   lce_cmd_yumi_i  in   LCE consumes the message (only legal while valid)
// ---------------------------------------------------------------------------
module bp_lce_cmd_deserializer
    import bp_lce_cmd_deserializer_pkg::*;
#(
    parameter int header_width_p = 96,
    parameter int block_width_p  = 512,
    parameter int flit_width_p   = 64,
    parameter int has_data_bit_p = 0,
    parameter int size_lsb_p     = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [flit_width_p-1:0]                 flit_i,
    input  logic                                    flit_v_i,
    output logic                                    flit_ready_o,
    output logic [header_width_p+block_width_p-1:0] lce_cmd_o,
    output logic                                    lce_cmd_v_o,
    input  logic                                    lce_cmd_yumi_i
);

    localparam int header_flits_lp   = (header_width_p + flit_width_p - 1) / flit_width_p;
    localparam int max_data_flits_lp = block_width_p / flit_width_p;
    localparam int max_flits_lp      = (header_flits_lp > max_data_flits_lp)
                                       ? header_flits_lp : max_data_flits_lp;
    localparam int cnt_width_lp      = $clog2(max_flits_lp + 1);

    bp_lce_cmd_deser_state_e state_r, state_n;

    logic [cnt_width_lp-1:0]   data_last_r, data_last_n;
    logic                      flit_hs, msg_hs;
    logic                      hdr_write, data_write, data_clear;
    logic                      hdr_last, data_last;
    logic [header_width_p-1:0] hdr_lo, hdr_next;
    logic [block_width_p-1:0]  data_lo, data_next;
    int                        data_flits;

    assign flit_ready_o = (state_r != e_out);
    assign lce_cmd_v_o  = (state_r == e_out);
    assign flit_hs      = flit_v_i & flit_ready_o;
    assign msg_hs       = lce_cmd_v_o & lce_cmd_yumi_i;
    assign lce_cmd_o    = {data_lo, hdr_lo};

    // Data length is decoded from the header as it will look once the
    // current flit is written, so the final header flit can carry the fields.
    assign data_flits = bp_msg_size_to_flits(hdr_next[size_lsb_p +: 3],
                                             flit_width_p, block_width_p);

    bp_me_flit_collector #(
        .width_p      (header_width_p),
        .flit_width_p (flit_width_p),
        .cnt_width_p  (cnt_width_lp)
    ) u_hdr (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (msg_hs),
        .write_i     (hdr_write),
        .flit_i      (flit_i),
        .last_cnt_i  (cnt_width_lp'(header_flits_lp - 1)),
        .last_o      (hdr_last),
        .data_o      (hdr_lo),
        .data_next_o (hdr_next)
    );

    bp_me_flit_collector #(
        .width_p      (block_width_p),
        .flit_width_p (flit_width_p),
        .cnt_width_p  (cnt_width_lp)
    ) u_data (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (data_clear),
        .write_i     (data_write),
        .flit_i      (flit_i),
        .last_cnt_i  (data_last_r),
        .last_o      (data_last),
        .data_o      (data_lo),
        .data_next_o (data_next)
    );

    // Only the decoded fields of the next-header view matter; the data
    // collector's next view is not needed at all.
    logic unused_next;
    assign unused_next = ^{hdr_next, data_next};

    always_comb begin
        state_n     = state_r;
        data_last_n = data_last_r;
        hdr_write   = 1'b0;
        data_write  = 1'b0;
        data_clear  = 1'b0;
        case (state_r)
            e_header: begin
                if (flit_hs) begin
                    hdr_write = 1'b1;
                    if (hdr_last) begin
                        // The data register is cleared on both paths so a
                        // no-data or short message presents zero upper data.
                        data_clear = 1'b1;
                        if (hdr_next[has_data_bit_p]) begin
                            data_last_n = cnt_width_lp'(data_flits - 1);
                            state_n     = e_data;
                        end else begin
                            state_n = e_out;
                        end
                    end
                end
            end
            e_data: begin
                if (flit_hs) begin
                    data_write = 1'b1;
                    if (data_last) begin
                        state_n = e_out;
                    end
                end
            end
            e_out: begin
                if (lce_cmd_yumi_i) begin
                    state_n = e_header;
                end
            end
            default: begin
                state_n = e_header;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_header;
            data_last_r <= '0;
        end else begin
            state_r     <= state_n;
            data_last_r <= data_last_n;
        end
    end

    // The LCE must never consume a message that is not being offered.
    a_no_yumi_without_v: assert property (@(posedge clk_i) disable iff (reset_i)
        !(lce_cmd_yumi_i && !lce_cmd_v_o));

endmodule
